// File: rtl/bus_arb_mux.sv
// rtl/bus_arb_mux.sv - Multi-source bus arbiter and data mux with conflict detection
module bus_arb_mux #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 24,
    parameter int MODE    = 0,
    parameter int REG_OUT = 1,
    localparam int GW     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_out,
    input  logic                  hold,
    input  logic                  conflict_clr,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic [GW-1:0]         grant_idx,
    output logic                  conflict,
    output logic                  conflict_sticky
);

    localparam logic [GW-1:0] LAST_IDX = GW'(NSRC - 1);
    localparam logic [GW:0]   NSRC_W   = (GW + 1)'(NSRC);

    logic [GW-1:0]    rr_ptr;
    logic [GW-1:0]    rr_start;
    logic [NSRC-1:0]  rot;
    logic [GW-1:0]    rr_pos;
    logic [GW:0]      rr_sum;
    logic [GW-1:0]    rr_idx;
    logic [GW-1:0]    hi_idx;
    logic [GW-1:0]    win_idx;
    logic [WIDTH-1:0] win_data;
    logic             any_req;
    logic             multi_req;

    logic [WIDTH-1:0] bus_q;
    logic [GW-1:0]    grant_q;
    logic             valid_q;
    logic             conflict_q;
    logic             sticky_q;

    // Round-robin search: rotate requests so the slot after rr_ptr lands at bit 0,
    // take the lowest set bit, then map back to an absolute source index.
    always_comb begin
        rr_start = (rr_ptr == LAST_IDX) ? '0 : rr_ptr + GW'(1);
        rot      = NSRC'({src_out, src_out} >> rr_start);
        rr_pos   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rr_pos = GW'(i);
            end
        end
        rr_sum = {1'b0, rr_start} + {1'b0, rr_pos};
        if (rr_sum >= NSRC_W) begin
            rr_sum = rr_sum - NSRC_W;
        end
        rr_idx = rr_sum[GW-1:0];
    end

    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_out[i]) begin
                hi_idx = GW'(i);
            end
        end
    end

    assign win_idx   = (MODE == 0) ? hi_idx : rr_idx;
    assign any_req   = |src_out;
    assign multi_req = |(src_out & (src_out - NSRC'(1)));

    // Only the granted word is gated onto the bus; all other sources contribute zero.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (win_idx == GW'(i)) begin
                win_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            bus_q      <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            rr_ptr     <= LAST_IDX;
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            conflict_q <= multi_req;
            sticky_q   <= multi_req | (sticky_q & ~conflict_clr);
            if (!hold) begin
                valid_q <= any_req;
                if (any_req) begin
                    bus_q   <= win_data;
                    grant_q <= win_idx;
                    rr_ptr  <= win_idx;
                end
            end
        end
    end

    // Combinational variant shows the live winner; idle or held cycles fall back to the registers.
    always_comb begin
        bus_out   = bus_q;
        grant_idx = grant_q;
        bus_valid = valid_q;
        if ((REG_OUT == 0) && clear_n && !hold) begin
            bus_valid = any_req;
            if (any_req) begin
                bus_out   = win_data;
                grant_idx = win_idx;
            end
        end
    end

    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// tb/tb_bus_arb_mux.sv - Randomized and directed checks of bus_arb_mux against a behavioural model
module tb_bus_arb_mux;

    localparam int W    = 32;
    localparam int NSRC = 24;
    localparam int GW   = 5;

    logic              clock        = 1'b0;
    logic              clear_n      = 1'b0;
    logic              hold         = 1'b0;
    logic              conflict_clr = 1'b0;
    logic [NSRC*W-1:0] src_data     = '0;
    logic [NSRC-1:0]   src_out      = '0;

    logic [W-1:0]  bus_o  [3];
    logic          val_o  [3];
    logic [GW-1:0] gnt_o  [3];
    logic          conf_o [3];
    logic          stk_o  [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    bus_arb_mux #(.WIDTH(W), .NSRC(NSRC), .MODE(0), .REG_OUT(1)) u_m0 (
        .clock(clock), .clear_n(clear_n), .src_data(src_data), .src_out(src_out),
        .hold(hold), .conflict_clr(conflict_clr), .bus_out(bus_o[0]), .bus_valid(val_o[0]),
        .grant_idx(gnt_o[0]), .conflict(conf_o[0]), .conflict_sticky(stk_o[0]));

    bus_arb_mux #(.WIDTH(W), .NSRC(NSRC), .MODE(1), .REG_OUT(1)) u_m1 (
        .clock(clock), .clear_n(clear_n), .src_data(src_data), .src_out(src_out),
        .hold(hold), .conflict_clr(conflict_clr), .bus_out(bus_o[1]), .bus_valid(val_o[1]),
        .grant_idx(gnt_o[1]), .conflict(conf_o[1]), .conflict_sticky(stk_o[1]));

    bus_arb_mux #(.WIDTH(W), .NSRC(NSRC), .MODE(1), .REG_OUT(0)) u_c1 (
        .clock(clock), .clear_n(clear_n), .src_data(src_data), .src_out(src_out),
        .hold(hold), .conflict_clr(conflict_clr), .bus_out(bus_o[2]), .bus_valid(val_o[2]),
        .grant_idx(gnt_o[2]), .conflict(conf_o[2]), .conflict_sticky(stk_o[2]));

    int mode_of [3] = '{0, 1, 1};
    bit reg_of  [3] = '{1'b1, 1'b1, 1'b0};

    int           m_rr  [3];
    logic [W-1:0] m_bus [3];
    int           m_gnt [3];
    bit           m_val [3];
    bit           m_conf;
    bit           m_stk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word(input int i);
        return src_data[i*W +: W];
    endfunction

    function automatic int pick(input int inst);
        if (src_out == '0) return -1;
        if (mode_of[inst] == 0) begin
            for (int i = NSRC - 1; i >= 0; i--)
                if (src_out[i]) return i;
        end else begin
            for (int k = 1; k <= NSRC; k++) begin
                int j;
                j = (m_rr[inst] + k) % NSRC;
                if (src_out[j]) return j;
            end
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_rr[i]  = NSRC - 1;
            m_bus[i] = '0;
            m_gnt[i] = 0;
            m_val[i] = 1'b0;
        end
        m_conf = 1'b0;
        m_stk  = 1'b0;
    endfunction

    function automatic void model_step();
        int w;
        m_conf = ($countones(src_out) >= 2);
        m_stk  = m_conf || (m_stk && !conflict_clr);
        if (!hold) begin
            for (int i = 0; i < 3; i++) begin
                w = pick(i);
                m_val[i] = (w >= 0);
                if (w >= 0) begin
                    m_bus[i] = word(w);
                    m_gnt[i] = w;
                    m_rr[i]  = w;
                end
            end
        end
    endfunction

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) model_reset();
        else          model_step();
    end

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            logic [W-1:0] eb;
            int           eg;
            bit           ev;
            int           w;
            eb = m_bus[k];
            eg = m_gnt[k];
            ev = m_val[k];
            if (!reg_of[k] && clear_n && !hold) begin
                w  = pick(k);
                ev = (w >= 0);
                if (w >= 0) begin
                    eb = word(w);
                    eg = w;
                end
            end
            chk($sformatf("bus_out[%0d]", k),   64'(bus_o[k]),  64'(eb));
            chk($sformatf("grant_idx[%0d]", k), 64'(gnt_o[k]),  64'(eg));
            chk($sformatf("bus_valid[%0d]", k), 64'(val_o[k]),  64'(ev));
            chk($sformatf("conflict[%0d]", k),  64'(conf_o[k]), 64'(m_conf));
            chk($sformatf("sticky[%0d]", k),    64'(stk_o[k]),  64'(m_stk));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk_out(input int inst, input string tag, input logic [W-1:0] b, input int g, input bit v);
        chk({tag, "_bus"},   64'(bus_o[inst]), 64'(b));
        chk({tag, "_grant"}, 64'(gnt_o[inst]), 64'(g));
        chk({tag, "_valid"}, 64'(val_o[inst]), 64'(v));
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk_out(k, tag, '0, 0, 1'b0);
            chk({tag, "_conf"}, 64'(conf_o[k]), 64'(0));
            chk({tag, "_stk"},  64'(stk_o[k]),  64'(0));
        end
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #2 clear_n = 1'b0;
        #1 chk_all_zero("reset_pulse");
        #1 clear_n = 1'b1;
    endtask

    int exp_rr [4] = '{2, 5, 9, 2};

    initial begin
        model_reset();
        for (int i = 0; i < NSRC; i++) src_data[i*W +: W] = $urandom;
        #3 chk_all_zero("reset");
        tick();
        clear_n = 1'b1;

        src_data[3*W +: W]  = 32'h1111_1111;
        src_data[17*W +: W] = 32'h2222_2222;
        src_out = (NSRC'(1) << 3) | (NSRC'(1) << 17);
        tick();
        chk_out(0, "fixed_prio", 32'h2222_2222, 17, 1'b1);
        chk("fixed_prio_conf", 64'(conf_o[0]), 64'(1));
        chk("fixed_prio_stk",  64'(stk_o[0]),  64'(1));
        src_out = '0;
        tick();

        pulse_reset();
        src_out = (NSRC'(1) << 2) | (NSRC'(1) << 5) | (NSRC'(1) << 9);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rr_seq%0d", c), 64'(gnt_o[1]), 64'(exp_rr[c]));
        end

        pulse_reset();
        src_out = NSRC'(1);
        tick();
        chk("rr_wrap0", 64'(gnt_o[1]), 64'(0));
        src_out = NSRC'(1) << 23;
        tick();
        chk("rr_top", 64'(gnt_o[1]), 64'(23));
        src_out = NSRC'(1);
        tick();
        chk("rr_wrap1", 64'(gnt_o[1]), 64'(0));

        src_data[6*W +: W] = 32'hDEAD_BEEF;
        src_out = NSRC'(1) << 6;
        tick();
        chk_out(0, "beef", 32'hDEAD_BEEF, 6, 1'b1);
        src_out = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out(0, $sformatf("idle%0d", c), 32'hDEAD_BEEF, 6, 1'b0);
        end

        src_out = NSRC'(1) << 7;
        tick();
        hold    = 1'b1;
        src_out = (NSRC'(1) << 4) | (NSRC'(1) << 1);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk_out(0, $sformatf("hold%0d", c), word(7), 7, 1'b1);
            chk_out(1, $sformatf("hold_rr%0d", c), word(7), 7, 1'b1);
            chk($sformatf("hold_conf%0d", c), 64'(conf_o[0]), 64'(1));
        end
        hold = 1'b0;
        tick();
        chk("release_fixed", 64'(gnt_o[0]), 64'(4));
        chk("release_rr",    64'(gnt_o[1]), 64'(1));

        conflict_clr = 1'b1;
        src_out = NSRC'(1) << 4;
        tick();
        chk("sticky_clr", 64'(stk_o[0]), 64'(0));
        chk("conf_single", 64'(conf_o[0]), 64'(0));
        src_out = NSRC'(3);
        tick();
        chk("sticky_set_wins", 64'(stk_o[0]), 64'(1));
        conflict_clr = 1'b0;

        src_out = NSRC'(1) << 5;
        pulse_reset();
        tick();
        chk_out(0, "fresh_after_reset", word(5), 5, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < NSRC; i++) src_data[i*W +: W] = $urandom;
            case ($urandom_range(0, 3))
                0: src_out = '0;
                1: begin
                    src_out = '0;
                    src_out[$urandom_range(0, NSRC - 1)] = 1'b1;
                end
                2: begin
                    src_out = '0;
                    src_out[$urandom_range(0, NSRC - 1)] = 1'b1;
                    src_out[$urandom_range(0, NSRC - 1)] = 1'b1;
                end
                default: src_out = NSRC'($urandom);
            endcase
            hold         = ($urandom_range(0, 7) == 0);
            conflict_clr = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 clear_n = 1'b0;
                #1 clear_n = 1'b1;
            end
        end

        @(posedge clock);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
